// File: rtl/data_memory_if.sv
// -----------------------------------------------------------------------------
// data_memory_if
//
// Bus between the CPU memory stage (master) and the data memory (slave).
//
// Handshake: MEM_READ / MEM_WRITE form the request. The master raises one or
// both and holds every request field stable for as long as BUSYWAIT is high.
// The cycle in which BUSYWAIT drops back to 0 is the completion cycle. In that
// cycle READ_DATA holds a completed load and MISALIGNED reports the access.
// The request may still be visible then, but the slave treats it as the
// finished access and ignores it. A request seen in the following cycle starts
// a new access. There is no ready signal and no pipelining of accesses.
//
// Signals:
//   MEM_READ        master -> slave  load request
//   MEM_WRITE       master -> slave  store request (wins over MEM_READ)
//   FUNC3           master -> slave  load/store access type
//   MEM_ADDRESS     master -> slave  byte address
//   MEM_WRITE_DATA  master -> slave  store data
//   READ_DATA       slave -> master  extended load result, registered
//   BUSYWAIT        slave -> master  pipeline stall request
//   MISALIGNED      slave -> master  misaligned-access flag, completion cycle
// -----------------------------------------------------------------------------
interface data_memory_if;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNC3;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;

    modport master (
        output MEM_READ, MEM_WRITE, FUNC3, MEM_ADDRESS, MEM_WRITE_DATA,
        input  READ_DATA, BUSYWAIT, MISALIGNED
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, FUNC3, MEM_ADDRESS, MEM_WRITE_DATA,
        output READ_DATA, BUSYWAIT, MISALIGNED
    );
endinterface

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Byte-addressable data memory that answers the CPU memory stage. A request
// stalls the pipeline through BUSYWAIT for LATENCY+1 cycles. It then performs
// a sign/zero-extended load into READ_DATA, or a byte-lane-masked store.
//
// Parameters:
//   ADDR_WIDTH  word-index width; 2**ADDR_WIDTH words of 32 bits
//   LATENCY     cycles spent in ACCESS, 1..15
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      synchronous active-low reset
//   bus        data_memory_if slave modport (request, READ_DATA, BUSYWAIT,
//              MISALIGNED)
//   fsm_state  current FSM state, for observation (IDLE=0, ACCESS=1, DONE=2)
//
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned halfword
// and word accesses. A flagged access raises MISALIGNED in the completion
// cycle. A flagged store is dropped, and a flagged load returns 0. When the
// macro is undefined, MISALIGNED is tied to 0. In that case halfword accesses
// use lane pair {addr[1],x} and word accesses ignore addr[1:0].
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    data_memory_if.slave bus,
    output logic [1:0]   fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic request;
    logic start;
    logic commit;
    logic busy;

    logic [3:0]            count;
    logic                  op_write;
    logic [2:0]            func3_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic [1:0]            offset_q;
    logic [31:0]           wdata_q;
    logic [31:0]           read_data_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic [31:0] word_rd;
    logic [7:0]  byte_rd;
    logic [15:0] half_rd;
    logic [31:0] load_value;
    logic [31:0] store_lanes;
    logic [3:0]  strobe;
    logic        misalign_hit;

    // Address bits above the word index alias onto the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.MEM_ADDRESS[31:ADDR_WIDTH+2];

    assign request = bus.MEM_READ | bus.MEM_WRITE;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        start      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                busy = request;
                if (request) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                if (count == 4'd0) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end
            end
            // The request still present here is the one just completed.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Reset wins over everything. This also drops a store whose commit
        // edge coincides with the reset edge.
        if (!RESET) begin
            busy   = 1'b0;
            start  = 1'b0;
            commit = 1'b0;
        end
    end

    assign fsm_state    = state;
    assign bus.BUSYWAIT = busy;

    // ------------------------------------------------------ latency counter
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            count <= 4'd0;
        end else if (start) begin
            count <= 4'(LATENCY - 1);
        end else if (state == ACCESS && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // ------------------------------------------------------ request capture
    // A simultaneous read+write is treated as a write.
    always_ff @(posedge CLK) begin
        if (start) begin
            op_write <= bus.MEM_WRITE;
            func3_q  <= bus.FUNC3;
            index_q  <= bus.MEM_ADDRESS[ADDR_WIDTH+1:2];
            offset_q <= bus.MEM_ADDRESS[1:0];
            wdata_q  <= bus.MEM_WRITE_DATA;
        end
    end

    // ------------------------------------------------------ misalignment
`ifdef DMEM_MISALIGN_CHECK_EN
    logic is_half;
    logic is_word;
    logic misaligned_q;

    // Reserved load codes behave as LW, so they are checked as words.
    // Reserved store codes write nothing and are never flagged.
    always_comb begin
        is_half = 1'b0;
        is_word = 1'b0;
        if (op_write) begin
            is_half = (func3_q == 3'b001);
            is_word = (func3_q == 3'b010);
        end else begin
            is_half = (func3_q == 3'b001) || (func3_q == 3'b101);
            is_word = !((func3_q == 3'b000) || (func3_q == 3'b001) ||
                        (func3_q == 3'b100) || (func3_q == 3'b101));
        end
    end

    assign misalign_hit = (is_half && offset_q[0]) ||
                          (is_word && (offset_q != 2'b00));

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            misaligned_q <= 1'b0;
        end else begin
            // Set on the commit edge, so it is high in the DONE cycle only.
            misaligned_q <= commit & misalign_hit;
        end
    end

    assign bus.MISALIGNED = misaligned_q;
`else
    assign misalign_hit   = 1'b0;
    assign bus.MISALIGNED = 1'b0;
`endif

    // ------------------------------------------------------ load path
    assign word_rd = mem[index_q];

    always_comb begin
        byte_rd = word_rd[{offset_q, 3'b000} +: 8];
        half_rd = offset_q[1] ? word_rd[31:16] : word_rd[15:0];
        case (func3_q)
            3'b000:  load_value = {{24{byte_rd[7]}}, byte_rd};
            3'b001:  load_value = {{16{half_rd[15]}}, half_rd};
            3'b100:  load_value = {24'h0, byte_rd};
            3'b101:  load_value = {16'h0, half_rd};
            default: load_value = word_rd;
        endcase
        if (misalign_hit) begin
            load_value = 32'h0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            read_data_q <= 32'h0;
        end else if (commit && !op_write) begin
            read_data_q <= load_value;
        end
    end

    assign bus.READ_DATA = read_data_q;

    // ------------------------------------------------------ store path
    // Store data is replicated across lanes so the strobe alone picks the
    // bytes that land.
    always_comb begin
        strobe      = 4'b0000;
        store_lanes = wdata_q;
        case (func3_q)
            3'b000: begin
                strobe      = 4'b0001 << offset_q;
                store_lanes = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                strobe      = offset_q[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                strobe      = 4'b1111;
                store_lanes = wdata_q;
            end
            default: begin
                strobe      = 4'b0000;
                store_lanes = wdata_q;
            end
        endcase
        if (misalign_hit) begin
            strobe = 4'b0000;
        end
    end

    // Memory contents are deliberately outside the reset domain.
    always_ff @(posedge CLK) begin
        if (commit && op_write) begin
            for (int k = 0; k < 4; k++) begin
                if (strobe[k]) begin
                    mem[index_q][8*k +: 8] <= store_lanes[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//
// Self-checking bench for data_memory. A byte-array reference model supplies
// expected load results and store effects. A fixed latency of LAT+1 stall
// cycles is expected per access. Directed scenarios come first, then
// randomized traffic.
// -----------------------------------------------------------------------------
module tb_data_memory;

    localparam int AW    = 10;
    localparam int LAT   = 4;
    localparam int BYTES = 4 << AW;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic       clk;
    logic       RESET;
    logic [1:0] unused_fsm_state;

    data_memory_if bus ();

    data_memory #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .CLK       (clk),
        .RESET     (RESET),
        .bus       (bus),
        .fsm_state (unused_fsm_state)
    );

    // ------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    // ------------------------------------------------ reference model
    logic [7:0]  ref_mem [BYTES];
    logic [31:0] exp_rd;
    int          n_checks;
    int          n_fail;

    function automatic bit model_misaligned(input bit is_wr, input logic [2:0] f3,
                                            input logic [31:0] a);
        bit half;
        bit word;
        if (is_wr) begin
            half = (f3 == 3'b001);
            word = (f3 == 3'b010);
        end else begin
            half = (f3 == 3'b001) || (f3 == 3'b101);
            word = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101);
        end
        return CHECK_EN && ((half && a[0]) || (word && a[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int          ofs;
        int          base;
        int          hb;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        logic [31:0] r;
        ofs  = int'(a[AW+1:0]);
        base = ofs - (ofs % 4);
        hb   = base + 2 * int'(a[1]);
        b    = ref_mem[ofs];
        h    = {ref_mem[hb+1], ref_mem[hb]};
        w    = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d);
        int ofs;
        int base;
        int hb;
        ofs  = int'(a[AW+1:0]);
        base = ofs - (ofs % 4);
        hb   = base + 2 * int'(a[1]);
        if (model_misaligned(1'b1, f3, a)) return;
        case (f3)
            3'b000: ref_mem[ofs] = d[7:0];
            3'b001: begin
                ref_mem[hb]   = d[7:0];
                ref_mem[hb+1] = d[15:8];
            end
            3'b010: begin
                for (int k = 0; k < 4; k++) ref_mem[base+k] = d[8*k +: 8];
            end
            default: ;
        endcase
    endtask

    // ------------------------------------------------ driver
    // Called at the start of a cycle (just after a rising edge). Returns at
    // the start of the cycle after the completion cycle.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             output int busy_cnt, output bit done,
                             output logic [31:0] rdata, output logic mis,
                             output logic mis_early);
        bus.MEM_READ       = rd;
        bus.MEM_WRITE      = wr;
        bus.FUNC3          = f3;
        bus.MEM_ADDRESS    = a;
        bus.MEM_WRITE_DATA = d;
        busy_cnt  = 0;
        done      = 1'b0;
        rdata     = 32'h0;
        mis       = 1'b0;
        mis_early = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.BUSYWAIT === 1'b1) begin
                busy_cnt++;
                if (bus.MISALIGNED !== 1'b0) mis_early = 1'b1;
            end else begin
                done  = 1'b1;
                rdata = bus.READ_DATA;
                mis   = bus.MISALIGNED;
            end
            @(posedge clk);
            #1;
        end
        bus.MEM_READ  = 1'b0;
        bus.MEM_WRITE = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------ scenarios
    task automatic test_reset;
        RESET        = 1'b0;
        bus.MEM_READ = 1'b1;
        bus.FUNC3    = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_forced: BUSYWAIT %b, required 0", bus.BUSYWAIT);
        end
        n_checks++;
        if (bus.READ_DATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_read_data: READ_DATA %h, required 0", bus.READ_DATA);
        end
        n_checks++;
        if (bus.MISALIGNED !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_misaligned: MISALIGNED %b, required 0", bus.MISALIGNED);
        end
        @(posedge clk);
        #1;
        RESET        = 1'b1;
        bus.MEM_READ = 1'b0;
        exp_rd       = 32'h0;
        @(negedge clk);
        n_checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: BUSYWAIT %b, required 0", bus.BUSYWAIT);
        end
        @(posedge clk);
        #1;
    endtask

    // Gives every byte the random traffic can reach a known value.
    task automatic test_fill;
        int          bc;
        bit          dn;
        logic [31:0] r;
        logic [31:0] d;
        logic        m;
        logic        me;
        for (int w = 0; w < 64; w++) begin
            d = $urandom;
            model_store(3'b010, 32'(w * 4), d);
            do_access(1'b0, 1'b1, 3'b010, 32'(w * 4), d, bc, dn, r, m, me);
            n_checks++;
            if (!dn || bc != LAT + 1) begin
                n_fail++;
                $display("FAIL fill_busy: word %0d busy cycles %0d done %0d, required %0d",
                         w, bc, dn, LAT + 1);
            end
        end
    endtask

    task automatic test_sw_lw;
        int          bc;
        bit          dn;
        logic [31:0] r;
        logic        m;
        logic        me;
        model_store(3'b010, 32'h10, 32'hDEADBEEF);
        do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, bc, dn, r, m, me);
        n_checks++;
        if (!dn || bc != LAT + 1) begin
            n_fail++;
            $display("FAIL sw_busy: busy cycles %0d done %0d, required %0d", bc, dn, LAT + 1);
        end
        n_checks++;
        if (r !== exp_rd) begin
            n_fail++;
            $display("FAIL sw_read_hold: READ_DATA %h, required %h", r, exp_rd);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, bc, dn, r, m, me);
        exp_rd = 32'hDEADBEEF;
        n_checks++;
        if (!dn || bc != LAT + 1) begin
            n_fail++;
            $display("FAIL lw_busy: busy cycles %0d done %0d, required %0d", bc, dn, LAT + 1);
        end
        n_checks++;
        if (r !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lw_data: READ_DATA %h, required deadbeef", r);
        end
    endtask

    task automatic test_extension;
        bit          wrs  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b001, 3'b101};
        logic [31:0] adrs [6] = '{32'h21, 32'h21, 32'h21, 32'h22, 32'h22, 32'h22};
        logic [31:0] dats [6] = '{32'h80, 32'h0, 32'h0, 32'h8001, 32'h0, 32'h0};
        logic [31:0] exps [6] = '{32'h0, 32'hFFFFFF80, 32'h00000080,
                                  32'h0, 32'hFFFF8001, 32'h00008001};
        int          bc;
        bit          dn;
        logic [31:0] r;
        logic [31:0] e;
        logic        m;
        logic        me;
        for (int i = 0; i < 6; i++) begin
            if (wrs[i]) begin
                model_store(f3s[i], adrs[i], dats[i]);
                e = exp_rd;
            end else begin
                e      = exps[i];
                exp_rd = e;
            end
            do_access(!wrs[i], wrs[i], f3s[i], adrs[i], dats[i], bc, dn, r, m, me);
            n_checks++;
            if (!dn || bc != LAT + 1 || r !== e) begin
                n_fail++;
                $display("FAIL extension step %0d: busy %0d data %h, required busy %0d data %h",
                         i, bc, r, LAT + 1, e);
            end
        end
    endtask

    task automatic test_lanes;
        bit          wrs  [3] = '{1'b1, 1'b1, 1'b0};
        logic [2:0]  f3s  [3] = '{3'b010, 3'b000, 3'b010};
        logic [31:0] adrs [3] = '{32'h30, 32'h32, 32'h30};
        logic [31:0] dats [3] = '{32'h11223344, 32'hAA, 32'h0};
        int          bc;
        bit          dn;
        logic [31:0] r;
        logic [31:0] e;
        logic        m;
        logic        me;
        for (int i = 0; i < 3; i++) begin
            if (wrs[i]) begin
                model_store(f3s[i], adrs[i], dats[i]);
                e = exp_rd;
            end else begin
                e      = 32'h11AA3344;
                exp_rd = e;
            end
            do_access(!wrs[i], wrs[i], f3s[i], adrs[i], dats[i], bc, dn, r, m, me);
            n_checks++;
            if (!dn || bc != LAT + 1 || r !== e) begin
                n_fail++;
                $display("FAIL lanes step %0d: busy %0d data %h, required busy %0d data %h",
                         i, bc, r, LAT + 1, e);
            end
        end
    endtask

    task automatic test_reset_mid_access;
        int          bc;
        bit          dn;
        logic [31:0] r;
        logic [31:0] old;
        logic        m;
        logic        me;
        model_store(3'b010, 32'h40, 32'h0);
        do_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h0, bc, dn, r, m, me);
        do_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, bc, dn, r, m, me);
        exp_rd = model_load(3'b010, 32'h30);
        n_checks++;
        if (r !== exp_rd) begin
            n_fail++;
            $display("FAIL pre_reset_load: READ_DATA %h, required %h", r, exp_rd);
        end
        // Store abandoned by a reset sampled at the end of cycle 2.
        bus.MEM_WRITE      = 1'b1;
        bus.FUNC3          = 3'b010;
        bus.MEM_ADDRESS    = 32'h40;
        bus.MEM_WRITE_DATA = 32'h12345678;
        idle_cycles(2);
        RESET = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_busy_forced: BUSYWAIT %b, required 0", bus.BUSYWAIT);
        end
        @(posedge clk);
        #1;
        RESET         = 1'b1;
        bus.MEM_WRITE = 1'b0;
        exp_rd        = 32'h0;
        @(negedge clk);
        n_checks++;
        if (bus.BUSYWAIT !== 1'b0 || bus.READ_DATA !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_after: BUSYWAIT %b READ_DATA %h, required 0 and 0",
                     bus.BUSYWAIT, bus.READ_DATA);
        end
        @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, bc, dn, r, m, me);
        n_checks++;
        if (!dn || bc != LAT + 1 || r !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_dropped: busy %0d data %h, required busy %0d data 0",
                     bc, r, LAT + 1);
        end
        // Store whose commit edge is the reset edge.
        do_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, bc, dn, r, m, me);
        exp_rd = model_load(3'b010, 32'h30);
        old    = model_load(3'b010, 32'h44);
        bus.MEM_WRITE      = 1'b1;
        bus.FUNC3          = 3'b010;
        bus.MEM_ADDRESS    = 32'h44;
        bus.MEM_WRITE_DATA = ~old;
        idle_cycles(LAT);
        RESET = 1'b0;
        @(posedge clk);
        #1;
        RESET         = 1'b1;
        bus.MEM_WRITE = 1'b0;
        exp_rd        = 32'h0;
        @(negedge clk);
        n_checks++;
        if (bus.BUSYWAIT !== 1'b0 || bus.READ_DATA !== 32'h0) begin
            n_fail++;
            $display("FAIL commit_reset_after: BUSYWAIT %b READ_DATA %h, required 0 and 0",
                     bus.BUSYWAIT, bus.READ_DATA);
        end
        @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, bc, dn, r, m, me);
        exp_rd = old;
        n_checks++;
        if (!dn || r !== old) begin
            n_fail++;
            $display("FAIL commit_reset_dropped: data %h, required %h", r, old);
        end
    endtask

    task automatic test_back_to_back;
        int          bc;
        bit          dn;
        logic [31:0] r;
        logic        m;
        logic        me;
        model_store(3'b010, 32'h50, 32'h5);
        do_access(1'b1, 1'b1, 3'b010, 32'h50, 32'h5, bc, dn, r, m, me);
        n_checks++;
        if (!dn || bc != LAT + 1 || r !== exp_rd) begin
            n_fail++;
            $display("FAIL rw_both: busy %0d data %h, required busy %0d data %h",
                     bc, r, LAT + 1, exp_rd);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h50, 32'h0, bc, dn, r, m, me);
        exp_rd = 32'h5;
        n_checks++;
        if (!dn || bc != LAT + 1 || r !== 32'h5) begin
            n_fail++;
            $display("FAIL back_to_back: busy %0d data %h, required busy %0d data 00000005",
                     bc, r, LAT + 1);
        end
    endtask

    task automatic test_misalign;
        int          bc;
        bit          dn;
        logic [31:0] r;
        logic [31:0] e;
        logic        m;
        logic        me;
        logic        em;
        em     = model_misaligned(1'b0, 3'b010, 32'h13);
        e      = em ? 32'h0 : model_load(3'b010, 32'h13);
        exp_rd = e;
        do_access(1'b1, 1'b0, 3'b010, 32'h13, 32'h0, bc, dn, r, m, me);
        n_checks++;
        if (!dn || bc != LAT + 1 || r !== e || m !== em || me !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_lw: busy %0d data %h mis %b early %b, required %0d %h %b 0",
                     bc, r, m, me, LAT + 1, e, em);
        end
        model_store(3'b001, 32'h15, 32'hBEEF);
        em = model_misaligned(1'b1, 3'b001, 32'h15);
        do_access(1'b0, 1'b1, 3'b001, 32'h15, 32'hBEEF, bc, dn, r, m, me);
        n_checks++;
        if (!dn || m !== em || me !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_sh: mis %b early %b, required %b 0", m, me, em);
        end
        e      = model_load(3'b010, 32'h14);
        exp_rd = e;
        do_access(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, bc, dn, r, m, me);
        n_checks++;
        if (r !== e || m !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_sh_effect: data %h mis %b, required %h 0", r, m, e);
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] exp_q [$];
        bit          exp_mis_q [$];
        int          sel;
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        bit          mis;
        int          bc;
        bit          dn;
        logic [31:0] r;
        logic [31:0] e;
        logic        m;
        logic        me;
        bit          em;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 9);
            wr  = (sel <= 3) || (sel == 9);
            rd  = (sel >= 4);
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            a[AW+1:8] = '0;
            d   = $urandom;
            mis = model_misaligned(wr, f3, a);
            if (wr) begin
                model_store(f3, a, d);
            end else begin
                exp_rd = mis ? 32'h0 : model_load(f3, a);
            end
            exp_q.push_back(exp_rd);
            exp_mis_q.push_back(mis);
            do_access(rd, wr, f3, a, d, bc, dn, r, m, me);
            e  = exp_q.pop_front();
            em = exp_mis_q.pop_front();
            n_checks++;
            if (!dn || bc != LAT + 1) begin
                n_fail++;
                $display("FAIL rand_busy #%0d: busy %0d done %0d, required %0d", i, bc, dn, LAT + 1);
            end
            n_checks++;
            if (r !== e) begin
                n_fail++;
                $display("FAIL rand_data #%0d rd=%0d wr=%0d f3=%0d a=%h: READ_DATA %h, required %h",
                         i, rd, wr, f3, a, r, e);
            end
            n_checks++;
            if (m !== em || me !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_mis #%0d: mis %b early %b, required %b 0", i, m, me, em);
            end
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    // ------------------------------------------------ sequence + report
    initial begin
        n_checks           = 0;
        n_fail             = 0;
        exp_rd             = 32'h0;
        RESET              = 1'b0;
        bus.MEM_READ       = 1'b0;
        bus.MEM_WRITE      = 1'b0;
        bus.FUNC3          = 3'b000;
        bus.MEM_ADDRESS    = 32'h0;
        bus.MEM_WRITE_DATA = 32'h0;

        test_reset();
        test_fill();
        test_sw_lw();
        test_extension();
        test_lanes();
        test_reset_mid_access();
        test_back_to_back();
        test_misalign();
        test_random(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
